// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, redirect flush and load-use
// interlock against the E/M scoreboard. Define HAZARD_PERF_EN to add stall_count.
module hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rd_D,
  input  logic        uses_rs1_D,
  input  logic        uses_rs2_D,
  input  logic        writes_rd_D,
  input  logic        redirect_M,
  input  logic        mem_req_M,
  input  logic        mem_ready,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        stall_WB,
  output logic        flush_F,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_M,
  output logic        flush_WB,
  output logic        mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic {RUN, MWAIT} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     r_state;
  logic       r_sbe_vld;
  logic [4:0] r_sbe_rd;
  logic       r_sbm_vld;
  logic [4:0] r_sbm_rd;
  logic [7:0] r_wcnt;
  logic       r_mem_err;

  logic       w_mwait;
  logic       w_redirect;
  logic       w_hazard;
  logic       w_rs1_hit;
  logic       w_rs2_hit;
  logic [7:0] w_wcnt_nxt;

  // x0 never creates a dependency; writeback is not checked because the
  // register file writes on the falling edge.
  function automatic logic src_hit(input logic use_src, input logic [4:0] src);
    return use_src && (src != '0) &&
           ((r_sbe_vld && (r_sbe_rd == src)) || (r_sbm_vld && (r_sbm_rd == src)));
  endfunction

  assign w_mwait    = mem_req_M & ~mem_ready;
  assign w_redirect = redirect_M & ~w_mwait;
  assign w_rs1_hit  = src_hit(uses_rs1_D, rs1_D);
  assign w_rs2_hit  = src_hit(uses_rs2_D, rs2_D);
  assign w_hazard   = ~w_mwait & ~w_redirect & (w_rs1_hit | w_rs2_hit);

  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    stall_WB = 1'b0;
    flush_F  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_M  = 1'b0;
    flush_WB = 1'b0;
    if (!reset) begin
      if (w_mwait) begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_E  = 1'b1;
        stall_M  = 1'b1;
        flush_WB = 1'b1;
      end else if (w_redirect) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
        flush_M = 1'b1;
      end else if (w_hazard) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // wcnt counts consecutive wait cycles, including the one that leaves RUN,
  // so mem_err rises right after the WAIT_MAX-th stalled cycle.
  assign w_wcnt_nxt = !w_mwait          ? '0 :
                      (r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_sbe_vld <= 1'b0;
      r_sbe_rd  <= '0;
      r_sbm_vld <= 1'b0;
      r_sbm_rd  <= '0;
      r_wcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (!w_mwait) begin
        r_sbm_vld <= r_sbe_vld & ~flush_M;
        r_sbm_rd  <= r_sbe_rd;
        r_sbe_vld <= writes_rd_D & (rd_D != '0) & ~flush_E;
        r_sbe_rd  <= rd_D;
      end
      case (r_state)
        RUN:     if (w_mwait) r_state <= MWAIT;
        MWAIT:   if (mem_ready || !mem_req_M) r_state <= RUN;
        default: r_state <= RUN;
      endcase
      r_wcnt <= w_wcnt_nxt;
      if (w_mwait && (w_wcnt_nxt == WAIT_LIM))
        r_mem_err <= 1'b1;
    end
  end

  assign mem_err = r_mem_err;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_count <= '0;
    else if (stall_D)
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, 15, memory wait cycles after which mem_err is flagged (range 1..255).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1_D  in  5  decode-stage source register 1.
- rs2_D  in  5  decode-stage source register 2.
- rd_D  in  5  decode-stage destination register.
- uses_rs1_D  in  1  decode instruction reads rs1.
- uses_rs2_D  in  1  decode instruction reads rs2.
- writes_rd_D  in  1  decode instruction writes rd.
- redirect_M  in  1  taken jump or branch resolved in memory stage.
- mem_req_M  in  1  memory-stage load or store active.
- mem_ready  in  1  data memory completes the current access this cycle.
- stall_F, stall_D, stall_E, stall_M, stall_WB  out  1 each  pipeline register hold enables.
- flush_F, flush_D, flush_E, flush_M, flush_WB  out  1 each  synchronous bubble inserts.
- mem_err  out  1  sticky memory-timeout flag.

Function
REQ-003 State: FSM {RUN, MWAIT}; scoreboard entries sb_E and sb_M, each {valid, rd[4:0]}; wait counter wcnt[7:0].
REQ-004 Stall and flush outputs are combinational from the current state and inputs; scoreboard, FSM, wcnt and mem_err are registered.
REQ-005 mwait = mem_req_M & ~mem_ready. It has the highest priority. It drives stall_F, stall_D, stall_E and stall_M to 1 and flush_WB to 1. All other outputs are 0.
REQ-006 redirect applies when redirect_M=1 and mwait=0. It drives flush_D, flush_E and flush_M to 1. All stalls are 0, and flush_F is 0 because F loads the target.
REQ-007 hazard applies when neither mwait nor redirect is active, a source register is used and nonzero, and a valid sb_E or sb_M entry has a matching rd. It drives stall_F, stall_D and flush_E to 1.
REQ-008 No hazard exists against the writeback stage, because the register file writes on the falling edge.
REQ-009 When none of the above applies, all ten outputs are 0. stall_WB and flush_F are always 0.
REQ-010 Scoreboard update in mwait: sb_E and sb_M hold.
REQ-011 Scoreboard update otherwise:
- sb_M <= sb_E, invalidated if flush_M=1.
- sb_E <= {writes_rd_D & (rd_D!=0), rd_D}, invalidated if flush_E=1.
REQ-012 FSM: RUN to MWAIT when mwait=1. MWAIT to RUN when mem_ready=1 or mem_req_M=0.
REQ-013 wcnt clears in RUN and increments by 1 each MWAIT cycle, saturating at 255.
REQ-014 When wcnt reaches WAIT_MAX, mem_err sets to 1 and stays set until reset. Stalling continues.
REQ-015 mem_ready and mem_req_M high in the same cycle is not a wait: that access completes with no stall.
REQ-016 Simultaneous mwait and redirect: redirect is deferred. redirect_M stays valid because M holds, and it is applied in the first cycle without mwait.
REQ-017 Back-to-back hazards: the stall repeats each cycle until sb_E and sb_M no longer match. The maximum hazard stall is 2 cycles.

Reset
REQ-018 reset=1 asynchronously forces: FSM=RUN, sb_E and sb_M invalid, wcnt=0, mem_err=0, and the stall_count option to 0.
REQ-019 While reset=1, all stall and flush outputs are 0.
REQ-020 Reset in mid-MWAIT or mid-hazard abandons that operation, with no residual stall after release.

Configuration
REQ-021 Macro HAZARD_PERF_EN.
- When defined: adds output stall_count (out, 32 bits). It increments on every clock where stall_D=1 and wraps from 0xFFFFFFFF to 0.
- When undefined: the port and the counter do not exist, and all other behaviour is identical.

Verification
REQ-022 Scenario: rd_D=5 with writes_rd_D=1, then the next instruction has rs1_D=5 -> stall_F=stall_D=flush_E=1 for exactly 2 cycles, then free.
REQ-023 Scenario: rd_D=0 with writes_rd_D=1, then the next instruction has rs1_D=0 -> no stall.
REQ-024 Scenario: redirect_M=1 for 1 cycle -> flush_D=flush_E=flush_M=1 for that cycle; sb_E and sb_M invalid afterwards.
REQ-025 Scenario: mem_req_M=1 with mem_ready low for 3 cycles -> stall_F..stall_M and flush_WB high for 3 cycles, FSM MWAIT, mem_err=0.
REQ-026 Scenario: WAIT_MAX=4 with mem_ready held low for 6 cycles -> mem_err=1 after the 4th wait cycle; it stays 1 after mem_ready until reset.
REQ-027 Scenario: redirect_M=1 together with mwait for 2 cycles -> only mwait outputs during those cycles; redirect flushes appear in cycle 3.
